// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if
// Bundles the request and memory signals of the store merge unit.
//   start/size/addr/b_out : store request from the control unit
//   mem_rdata             : read data returned by memory
//   mem_addr/mem_rd/mem_wr/mem_wdata : memory command side
//   busy/done/store_exception        : status back to the control unit
// The master modport is the environment (control unit plus memory).
// The slave modport is the store merge unit itself.
interface store_merge_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  start;
   logic [1:0]            size;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] b_out;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic                  mem_wr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  busy;
   logic                  done;
   logic                  store_exception;

   modport master (
      output start, size, addr, b_out, mem_rdata,
      input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, store_exception
   );

   modport slave (
      input  start, size, addr, b_out, mem_rdata,
      output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, store_exception
   );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Performs the memory side of a store for the multicycle datapath.
// Full-word stores are written straight out. Byte and halfword stores
// read the target word, merge the new lanes and write the word back.
// Illegal sizes and misaligned stores raise a one-cycle store_exception
// pulse and never touch memory.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : store_merge_unit_if slave modport (request, memory, status)
module store_merge_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   store_merge_unit_if.slave bus
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(LANES);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_FAULT
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [1:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [CNT_W-1:0]      r_count;

   logic                  w_illegal;
   logic [OFF-1:0]        w_offset;
   logic [DATA_WIDTH-1:0] w_merged;
   logic                  w_memRd;
   logic                  w_memWr;
   logic                  w_done;
   logic                  w_exc;
   logic                  w_busy;

   // Legality is judged on the live request inputs because it only
   // matters in the IDLE cycle where start is sampled. A halfword whose
   // first lane is the top lane would spill into the next word.
   always_comb begin
      w_illegal = 1'b0;
      case (bus.size)
         SZ_BYTE: w_illegal = 1'b0;
         SZ_HALF: w_illegal = bus.addr[0] || (bus.addr[OFF-1:0] == OFF'(LANES - 1));
         SZ_WORD: w_illegal = (bus.addr[OFF-1:0] != '0);
         default: w_illegal = 1'b1;
      endcase
   end

   // Lane merge: start from the word read back from memory and overlay
   // the store bytes at the lane picked by the latched address offset.
   // The halfword upper lane never wraps because that case is illegal.
   assign w_offset = r_addr[OFF-1:0];

   always_comb begin
      w_merged = bus.mem_rdata;
      for (int k = 0; k < LANES; k++) begin
         if (k == int'(w_offset)) begin
            w_merged[8*k +: 8] = r_data[7:0];
         end
         if ((r_size == SZ_HALF) && (k == int'(w_offset) + 1)) begin
            w_merged[8*k +: 8] = r_data[15:8];
         end
      end
   end

   // State register; reset wins over everything, including a start
   // arriving in the same cycle, and abandons any read-modify-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore output decode. Strobes come only from the
   // registered state, so start never reaches an output combinationally
   // and mem_rd/mem_wr are mutually exclusive by construction.
   always_comb begin
      w_nextState = r_state;
      w_memRd     = 1'b0;
      w_memWr     = 1'b0;
      w_done      = 1'b0;
      w_exc       = 1'b0;
      w_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (w_illegal) begin
                  w_nextState = S_FAULT;
               end else if (bus.size == SZ_WORD) begin
                  w_nextState = S_WRITE;
               end else begin
                  w_nextState = S_READ;
               end
            end
         end
         S_READ: begin
            w_memRd     = 1'b1;
            w_nextState = S_WAIT;
         end
         S_WAIT: begin
            if (r_count == '0) begin
               w_nextState = S_WRITE;
            end
         end
         S_WRITE: begin
            w_memWr     = 1'b1;
            w_nextState = S_DONE;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_nextState = S_IDLE;
         end
         S_FAULT: begin
            w_exc       = 1'b1;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Request latch, latency counter and write-data register. A full-word
   // store loads its data directly into the write register at accept time;
   // partial stores load it from the merge when the read data arrives.
   // The counter is loaded in READ so it holds MEM_LATENCY-1 on WAIT entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_size  <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wdata <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_size <= bus.size;
                  r_addr <= bus.addr;
                  r_data <= bus.b_out;
                  if (bus.size == SZ_WORD) begin
                     r_wdata <= bus.b_out;
                  end
               end
            end
            S_READ: begin
               r_count <= CNT_W'(MEM_LATENCY - 1);
            end
            S_WAIT: begin
               if (r_count == '0) begin
                  r_wdata <= w_merged;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The memory always sees a word-aligned address.
   assign bus.mem_addr        = {r_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
   assign bus.mem_rd          = w_memRd;
   assign bus.mem_wr          = w_memWr;
   assign bus.mem_wdata       = r_wdata;
   assign bus.busy            = w_busy;
   assign bus.done            = w_done;
   assign bus.store_exception = w_exc;

endmodule
